// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: checks the red/amber/green lines from a controller
// against the RED -> RED_AMBER -> GREEN -> AMBER loop, enforces per-phase
// minimum and maximum dwell, and latches the first error cause.
module traffic_light_monitor #(
  parameter int MIN_DWELL = 2,
  parameter int MAX_DWELL = 10,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             clr,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] seq_count
);

  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_ILLEGAL = 3'd1;
  localparam logic [2:0] E_ORDER   = 3'd2;
  localparam logic [2:0] E_SHORT   = 3'd3;
  localparam logic [2:0] E_LONG    = 3'd4;

  state_t           state, state_nxt;
  logic [1:0]       phase_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
  logic             partial, partial_nxt;
  logic [2:0]       cause;
  logic             seq_inc;
  logic             pat_legal;
  logic [1:0]       pat_phase;

  // Saturating dwell increment so a very long legal phase cannot wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Decode the sampled lamp pattern into a phase index and a legality flag.
  always_comb begin
    pat_legal = 1'b1;
    pat_phase = 2'd0;
    case ({red, amber, green})
      3'b100:  pat_phase = 2'd0;
      3'b110:  pat_phase = 2'd1;
      3'b001:  pat_phase = 2'd2;
      3'b010:  pat_phase = 2'd3;
      default: pat_legal = 1'b0;
    endcase
  end

  // Next-state logic: sequence tracking, dwell checks and error cause.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    dwell_nxt   = dwell_cnt;
    partial_nxt = partial;
    cause       = E_NONE;
    seq_inc     = 1'b0;
    case (state)
      SYNC: begin
        if (!pat_legal) begin
          cause = E_ILLEGAL;
        end else begin
          state_nxt   = TRACK;
          phase_nxt   = pat_phase;
          dwell_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
          partial_nxt = 1'b1;
        end
      end
      TRACK: begin
        if (!pat_legal) begin
          cause = E_ILLEGAL;
        end else if (pat_phase == phase) begin
          if (dwell_cnt == CNT_W'(MAX_DWELL)) cause = E_LONG;
          else dwell_nxt = sat_inc(dwell_cnt);
        end else if (pat_phase == phase + 2'd1) begin
          // The phase seen at lock time started before we were watching,
          // so its length is unknown and it is exempt from the short check.
          if (!partial && dwell_cnt < CNT_W'(MIN_DWELL)) begin
            cause = E_SHORT;
          end else begin
            seq_inc     = (phase == 2'd3);
            phase_nxt   = pat_phase;
            dwell_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
            partial_nxt = 1'b0;
          end
        end else begin
          cause = E_ORDER;
        end
        // Any error drops lock; the erroring sample is not reused for resync.
        if (cause != E_NONE) begin
          state_nxt = SYNC;
          dwell_nxt = '0;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Tracking state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SYNC;
      phase     <= 2'd0;
      dwell_cnt <= '0;
      partial   <= 1'b0;
      seq_count <= '0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      dwell_cnt <= dwell_nxt;
      partial   <= partial_nxt;
      if (seq_inc) seq_count <= seq_count + 1'b1;
    end
  end

  // Sticky error: first cause is kept; a new error on a clr edge wins over clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_code <= E_NONE;
    end else if (cause != E_NONE) begin
      err <= 1'b1;
      if (!err || clr) err_code <= cause;
    end else if (clr) begin
      err      <= 1'b0;
      err_code <= E_NONE;
    end
  end

  assign locked = (state == TRACK);

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Checker that sits on the output end of the traffic-light controller's red/amber/green lines and verifies them in hardware.
- Tracks the legal sequence RED -> RED_AMBER -> GREEN -> AMBER -> RED and enforces minimum and maximum dwell per phase.
- Flags illegal light patterns, out-of-order transitions and timing violations on a sticky error with a cause code.
- Counts completed sequences; used as an on-chip watchdog beside the controller and as a bench scoreboard.

Parameters:
- MIN_DWELL, 2, minimum sampled cycles a phase must last before it may change.
- MAX_DWELL, 10, maximum sampled cycles a phase may last; sample MAX_DWELL+1 of an unchanged phase is an error.
- CNT_W, 8, width of the dwell counter and the sequence counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- red  input  1  red lamp from controller.
- amber  input  1  amber lamp from controller.
- green  input  1  green lamp from controller.
- clr  input  1  synchronous clear of err/err_code.
- locked  output  1  monitor is synchronised to the sequence.
- phase  output  2  current phase: 0 RED(100), 1 RED_AMBER(110), 2 GREEN(001), 3 AMBER(010).
- err  output  1  sticky error flag.
- err_code  output  3  first error cause: 0 none, 1 illegal pattern, 2 wrong order, 3 dwell short, 4 dwell long.
- seq_count  output  CNT_W  completed AMBER->RED transitions, wraps modulo 2^CNT_W.

Behaviour:
- Reset: async on rst_n low. All outputs are 0, the FSM is in SYNC and dwell_cnt is 0.
- Timing: inputs are sampled on every rising edge. All outputs are registered, so an event sampled at edge N is visible after edge N.
- FSM states: SYNC and TRACK. In TRACK, phase holds the last legal pattern.
- Legal patterns: {r,a,g} = 100, 110, 001, 010. Illegal: 000, 011, 101, 111.
- SYNC handling:
  - An illegal sample stays in SYNC and raises error 1.
  - A legal sample moves to TRACK with phase set from the pattern, dwell_cnt=1 and partial=1.
  - locked=1 in TRACK.
- TRACK, pattern equal to phase:
  - dwell_cnt increments, saturating at 2^CNT_W-1.
  - If dwell_cnt==MAX_DWELL before the increment, raise error 4 and go to SYNC.
- TRACK, pattern is the next phase (mod 4):
  - If partial==0 and dwell_cnt<MIN_DWELL, raise error 3 and go to SYNC.
  - Otherwise advance phase, set dwell_cnt=1 and partial=0.
  - If the advance is AMBER->RED, increment seq_count.
- TRACK, pattern legal but not the next phase: raise error 2 and go to SYNC.
- TRACK, pattern illegal: raise error 1 and go to SYNC.
- Entering SYNC on error:
  - locked=0, dwell_cnt=0, phase holds its last value.
  - Resynchronisation starts at the next sample. The erroring sample itself is not reused.
- Error priority on a single sample: 1 > 2 > 3 > 4. Only one cause can apply per sample.
- Sticky rules:
  - err stays set once set.
  - err_code latches only when err was 0, so it holds the first cause.
  - The FSM keeps checking and resyncing while err=1.
- clr:
  - Sets err=0 and err_code=0 at the edge.
  - If a new error occurs on the same edge, the new error wins: err=1 and err_code is the new cause.
- seq_count is unaffected by errors and clr. It is cleared only by reset.
- Reset mid-operation returns immediately to the reset state. The first post-reset sample is treated as SYNC.

Test Plan:
1. Legal loop, defaults: drive 100, 110, 001, 010 for 3 cycles each, repeated 4 times, then 100 -> locked=1 from the first edge, err=0, seq_count=4, phase steps 0,1,2,3.
2. Illegal pattern: in TRACK in GREEN, drive 101 for 1 cycle -> err=1, err_code=1, locked=0 after that edge. Then drive 010 -> locked=1, phase=3, err stays 1.
3. Wrong order: RED for 3 cycles then 001 -> err_code=2. Then clr pulse with legal input -> err=0, err_code=0.
4. Dwell: RED for 3 cycles, RED_AMBER for 1 cycle, then GREEN -> err_code=3. Separately, GREEN held for 11 cycles -> err rises on sample 11 with err_code=4, locked=0.
5. Partial first phase and priority:
   - After reset, 1 cycle of 110 then 001 -> no error, because the partial phase is exempt from the short check.
   - With err already =1 and code 2, a new illegal sample leaves err_code=2.
   - clr on the same edge as a 111 sample gives err=1, err_code=1.
6. Async reset mid-GREEN with seq_count=3: pulse rst_n low between edges -> all outputs 0 immediately. The first sample after release at 010 gives locked=1 and phase=3.
